pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning payload width in bits (legal range 1..256).
REQ-002 The block SHALL have parameter CLEAR_ON_FLUSH, default 1, meaning that flush zeroes the stored payload (1) or leaves it unchanged (0).
REQ-003 The block SHALL have parameter RESET_DATA, default all zeros (DATA_W bits), meaning the payload register value after reset.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port flush_i, input, 1 bit: bubble/flush request that discards all held entries.
REQ-007 The block SHALL have port s_valid_i, input, 1 bit: upstream payload valid.
REQ-008 The block SHALL have port s_ready_o, output, 1 bit: the block accepts upstream payload.
REQ-009 The block SHALL have port s_data_i, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port m_valid_o, output, 1 bit: downstream payload valid.
REQ-011 The block SHALL have port m_ready_i, input, 1 bit: downstream accepts; low means stall.
REQ-012 The block SHALL have port m_data_o, output, DATA_W bits: downstream payload.
REQ-013 The block SHALL have port count_o, output, 2 bits: number of held entries (0..2).

Function
REQ-014 The block SHALL define the upstream transfer as s_valid_i & s_ready_o and the downstream transfer as m_valid_o & m_ready_i, each sampled at the rising edge.
REQ-015 The block SHALL implement states EMPTY (no entry), BUSY (main entry only) and FULL (main and skid entries).
REQ-016 The block SHALL drive s_ready_o = (state != FULL), m_valid_o = (state != EMPTY), m_data_o = main register and count_o = 0/1/2 for EMPTY/BUSY/FULL, all directly from registers with no combinational path from any input.
REQ-017 In EMPTY, an upstream transfer SHALL load main from s_data_i and go to BUSY; otherwise the block SHALL stay in EMPTY.
REQ-018 In BUSY, the block SHALL behave as follows: with both transfers, main loads s_data_i and the state stays BUSY; with upstream transfer only, skid loads s_data_i and the state goes to FULL; with downstream transfer only, the state goes to EMPTY; with neither, everything holds.
REQ-019 In FULL, a downstream transfer SHALL move skid into main and go to BUSY; otherwise all entries SHALL hold; s_data_i SHALL be ignored.
REQ-020 The block SHALL have a latency of 1 cycle from upstream transfer to m_valid_o when EMPTY, and SHALL sustain a throughput of one transfer per cycle with m_ready_i high.
REQ-021 The block SHALL preserve ordering, SHALL never drop or duplicate an entry, and SHALL keep m_data_o stable while m_valid_o=1 and m_ready_i=0.
REQ-022 flush_i=1 SHALL force the next state to EMPTY regardless of the current state or of any handshake in that cycle; the upstream payload of that cycle SHALL be discarded.
REQ-023 A downstream transfer coincident with flush_i SHALL count as consumed by the downstream stage; the block SHALL NOT re-present it.
REQ-024 On flush with CLEAR_ON_FLUSH=1, main and skid SHALL become zero; with CLEAR_ON_FLUSH=0, they SHALL hold their values.
REQ-025 The block SHALL give priority reset > flush_i > handshake.

Reset
REQ-026 When rst_n_i=0 at a rising edge, the block SHALL set state to EMPTY, main and skid to RESET_DATA, s_ready_o=1, m_valid_o=0, m_data_o=RESET_DATA and count_o=0.
REQ-027 Reset asserted mid-operation, including in FULL, SHALL discard all entries with no output transfer after that edge.

Structure
REQ-028 The shared pipeline package SHALL hold the 2-bit state enum (EMPTY=0, BUSY=1, FULL=2) and the default DATA_W constant.
REQ-029 The block SHALL be built from one sub-module, pipe_slot, a DATA_W-bit register with load, clear and hold, instantiated twice (main, skid).

Verification
REQ-030 The bench SHALL cover streaming: m_ready_i=1 and 8 consecutive words 0x1..0x8 -> m_data_o 0x1..0x8 on consecutive cycles, each 1 cycle later, with count_o=1 throughout.
REQ-031 The bench SHALL cover backpressure: drop m_ready_i while sending 0xA, 0xB, 0xC -> state FULL holding 0xA/0xB, s_ready_o=0, 0xC not accepted; raise m_ready_i -> 0xA, 0xB, 0xC delivered in order.
REQ-032 The bench SHALL cover flush in FULL with CLEAR_ON_FLUSH=1 and s_valid_i=1 -> next cycle count_o=0, m_valid_o=0, m_data_o=0, s_ready_o=1, input word lost.
REQ-033 The bench SHALL cover flush coincident with a downstream transfer of 0x55 -> 0x55 seen exactly once, then EMPTY.
REQ-034 The bench SHALL cover reset asserted in FULL -> next cycle count_o=0, m_valid_o=0, m_data_o=RESET_DATA.
REQ-035 The bench SHALL cover random valid/ready/flush over 10000 cycles against a FIFO scoreboard -> no loss, no duplication, order kept, count_o never above 2.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
package pipe_stage_skid_pkg;

  localparam int DEFAULT_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One payload register with synchronous clear (priority) and load; holds otherwise.
module pipe_slot
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i)     data_d = '0;
    else if (load_i) data_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) data_q <= RESET_VAL;
    else          data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: all outputs come straight from registers,
// so neither ready nor valid has a combinational path from any input.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W         = DEFAULT_DATA_W,
  parameter bit                CLEAR_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0] RESET_DATA     = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [1:0]        count_o
);

  state_e            state_q, state_d;
  logic              up_xfer, dn_xfer;
  logic              main_ld, skid_ld, slot_clr;
  logic [DATA_W-1:0] main_din, main_q, skid_q;

  assign s_ready_o = (state_q != ST_FULL);
  assign m_valid_o = (state_q != ST_EMPTY);
  assign m_data_o  = main_q;
  assign count_o   = 2'(state_q);

  assign up_xfer = s_valid_i & s_ready_o;
  assign dn_xfer = m_valid_o & m_ready_i;

  // Main refills from skid when draining FULL, otherwise from upstream.
  assign main_din = (state_q == ST_FULL) ? skid_q : s_data_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    slot_clr = 1'b0;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      slot_clr = CLEAR_ON_FLUSH;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            main_ld = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_ld = 1'b1;
          end else if (up_xfer) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_xfer) begin
            main_ld = 1'b1;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_DATA)) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (main_ld),
    .clear_i (slot_clr),
    .d_i     (main_din),
    .q_o     (main_q)
  );

  pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_DATA)) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_ld),
    .clear_i (slot_clr),
    .d_i     (s_data_i),
    .q_o     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: a depth-2 FIFO model predicts occupancy; a negedge monitor
// pops and compares every downstream transfer.
module tb_pipe_stage_skid;

  localparam int          DW   = 32;
  localparam logic [31:0] RDAT = 32'hA5A5_0F0F;

  logic          clk = 1'b0;
  logic          rst_n, flush, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [1:0]    count;

  int checks = 0;
  int errors = 0;
  int seen55 = 0;
  bit track55 = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .RESET_DATA(RDAT)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .flush_i   (flush),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .count_o   (count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every downstream transfer must be the oldest held word.
  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected act=%0h exp=none t=%0t", m_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("out_data", 64'(m_data), 64'(e));
        if (track55 && e == 32'h55) seen55++;
      end
    end
  end

  // One clock: drive inputs, advance the model at the edge, check state after it.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr,
                       input logic fl, input logic rs);
    bit acc;
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl; rst_n = rs;
    acc = rs && !fl && sv && (exp_q.size() < 2);
    @(posedge clk);
    if (!rs || fl) exp_q.delete();
    else if (acc)  exp_q.push_back(sd);
    #1;
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("s_ready", 64'(s_ready), 64'(exp_q.size() < 2));
    chk("m_valid", 64'(m_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("m_data_head", 64'(m_data), 64'(exp_q[0]));
  endtask

  initial begin
    // Reset
    cycle(1'b1, 32'h1234, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_data", 64'(m_data), 64'(RDAT));
    chk("reset_count", 64'(count), 64'd0);

    // Streaming 0x1..0x8 with ready high
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_data", 64'(m_data), 64'(i));
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure: A,B held, C refused until space frees
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    chk("bp_full_count", 64'(count), 64'd2);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_main", 64'(m_data), 64'hA);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
    chk("bp_after_a", 64'(m_data), 64'hB);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
    chk("bp_after_b", 64'(m_data), 64'hC);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("bp_drained", 64'(count), 64'd0);

    // Flush in FULL with a valid input word
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h77, 1'b0, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_m_valid", 64'(m_valid), 64'd0);
    chk("flush_m_data", 64'(m_data), 64'd0);
    chk("flush_s_ready", 64'(s_ready), 64'd1);

    // Flush coincident with a downstream transfer of 0x55
    track55 = 1;
    cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    track55 = 0;
    chk("flush_xfer_once", 64'(seen55), 64'd1);
    chk("flush_xfer_empty", 64'(count), 64'd0);

    // Reset in FULL
    cycle(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h44, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
    chk("rst_full_count", 64'(count), 64'd0);
    chk("rst_full_m_valid", 64'(m_valid), 64'd0);
    chk("rst_full_m_data", 64'(m_data), 64'(RDAT));

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), DW'($urandom),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3), 1'b1);
      chk("rand_count_max", 64'(count <= 2'd2), 64'd1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
